// File: rtl/uart_pkg.sv
// Shared register offsets, STATUS bit positions and TX state encoding for the
// memory-mapped UART transmitter.
package uart_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DIV    = 2'd2;

    localparam int unsigned ST_FULL   = 0;
    localparam int unsigned ST_EMPTY  = 1;
    localparam int unsigned ST_OVF    = 2;
    localparam int unsigned ST_CNT_LO = 8;

    localparam int unsigned DIV_W = 16;
    localparam int unsigned CNT_FIELD_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; pushes when full and pops when empty
// are ignored, and dout shows the head entry combinationally.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: 4-word register window on the core word
// bus, byte TX FIFO, programmable baud divisor and one-cycle registered reads.
module uart_tx_mmio
    import uart_pkg::*;
#(
    parameter logic [29:0]       BASE      = 30'h3fff_fffc,
    parameter int unsigned       DEPTH     = 16,
    parameter logic [DIV_W-1:0]  DIV_RESET = 16'd868
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [29:0] bus_addr,
    input  logic [31:0] bus_data_w,
    input  logic [3:0]  bus_mask_w,
    output logic [31:0] bus_data_r,
    output logic        uart_tx,
    output logic        irq_empty
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic             sel;
    logic [1:0]       off;
    logic             push_req;
    logic             pop;
    logic             ovf_set;
    logic             ovf_clr;
    logic             div_wr;
    logic             st_empty;
    logic [31:0]      status_word;
    logic [31:0]      rd_next;
    logic [DIV_W-1:0] eff_div;

    logic             fifo_full;
    logic             fifo_empty;
    logic [7:0]       fifo_dout;
    logic [CW-1:0]    fifo_count;

    logic             ovf;
    logic [DIV_W-1:0] div;

    tx_state_t        state;
    logic [7:0]       shift;
    logic [2:0]       bitcnt;
    logic [DIV_W-1:0] timer;

    logic             unused_bits;

    assign unused_bits = ^{bus_data_w[31:16], bus_mask_w[3:2]};

    // Address decode and write strobes.
    assign sel      = (bus_addr[29:2] == BASE[29:2]);
    assign off      = bus_addr[1:0];
    assign push_req = sel && (off == REG_DATA) && bus_mask_w[0];
    assign ovf_set  = push_req && fifo_full;
    assign ovf_clr  = sel && (off == REG_STATUS) && bus_mask_w[0] && bus_data_w[ST_OVF];
    assign div_wr   = sel && (off == REG_DIV);

    assign pop      = (state == IDLE) && !fifo_empty;
    assign eff_div  = (div == '0) ? DIV_W'(1) : div;
    assign st_empty = fifo_empty && (state == IDLE);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push_req),
        .pop   (pop),
        .din   (bus_data_w[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        status_word                             = '0;
        status_word[ST_FULL]                    = fifo_full;
        status_word[ST_EMPTY]                   = st_empty;
        status_word[ST_OVF]                     = ovf;
        status_word[ST_CNT_LO +: CNT_FIELD_W]   = CNT_FIELD_W'(fifo_count);
    end

    // Read mux samples pre-edge state; unselected cycles return zero for OR-ing.
    always_comb begin
        rd_next = '0;
        if (sel) begin
            case (off)
                REG_STATUS: rd_next = status_word;
                REG_DIV:    rd_next = {16'h0000, div};
                default:    rd_next = '0;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus_data_r <= '0;
            ovf        <= 1'b0;
            div        <= DIV_RESET;
            irq_empty  <= 1'b1;
        end else begin
            bus_data_r <= rd_next;
            irq_empty  <= st_empty;
            if (ovf_set) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
            if (div_wr && bus_mask_w[0]) begin
                div[7:0] <= bus_data_w[7:0];
            end
            if (div_wr && bus_mask_w[1]) begin
                div[15:8] <= bus_data_w[15:8];
            end
        end
    end

    // TX serialiser; the bit timer reloads from the live divisor at every bit boundary.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            shift   <= '0;
            bitcnt  <= '0;
            timer   <= '0;
            uart_tx <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    uart_tx <= 1'b1;
                    if (!fifo_empty) begin
                        shift   <= fifo_dout;
                        bitcnt  <= '0;
                        timer   <= eff_div;
                        uart_tx <= 1'b0;
                        state   <= START;
                    end
                end
                START: begin
                    if (timer == DIV_W'(1)) begin
                        timer   <= eff_div;
                        uart_tx <= shift[0];
                        state   <= DATA;
                    end else begin
                        timer <= timer - DIV_W'(1);
                    end
                end
                DATA: begin
                    if (timer == DIV_W'(1)) begin
                        timer <= eff_div;
                        if (bitcnt == 3'd7) begin
                            uart_tx <= 1'b1;
                            state   <= STOP;
                        end else begin
                            shift   <= {1'b0, shift[7:1]};
                            uart_tx <= shift[1];
                            bitcnt  <= bitcnt + 3'd1;
                        end
                    end else begin
                        timer <= timer - DIV_W'(1);
                    end
                end
                STOP: begin
                    if (timer == DIV_W'(1)) begin
                        uart_tx <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        timer <= timer - DIV_W'(1);
                    end
                end
                default: begin
                    uart_tx <= 1'b1;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio: register-access vector table, directed
// line-timing sequences and randomized frames against a per-bit timing model.
module tb_uart_tx_mmio;

    localparam logic [29:0] BASE      = 30'h3fff_fffc;
    localparam logic [29:0] A_DATA    = BASE;
    localparam logic [29:0] A_STAT    = BASE + 30'd1;
    localparam logic [29:0] A_DIV     = BASE + 30'd2;
    localparam logic [29:0] A_RSV     = BASE + 30'd3;
    localparam logic [29:0] A_ABOVE   = BASE + 30'd4;
    localparam logic [29:0] A_BELOW   = BASE - 30'd4;
    localparam logic [29:0] IDLE_ADDR = 30'h0000_1000;

    logic        clock;
    logic        reset;
    logic [29:0] bus_addr;
    logic [31:0] bus_data_w;
    logic [3:0]  bus_mask_w;
    logic [31:0] bus_data_r;
    logic        uart_tx;
    logic        irq_empty;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    logic hist [32768];

    uart_tx_mmio #(
        .BASE      (BASE),
        .DEPTH     (4),
        .DIV_RESET (16'd4)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .bus_addr   (bus_addr),
        .bus_data_w (bus_data_w),
        .bus_mask_w (bus_mask_w),
        .bus_data_r (bus_data_r),
        .uart_tx    (uart_tx),
        .irq_empty  (irq_empty)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // hist[n] holds the line value just after rising edge number n.
    always @(posedge clock) cyc <= cyc + 1;
    always @(posedge clock) begin
        #1;
        hist[cyc[14:0]] = uart_tx;
    end

    typedef struct {
        logic [29:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        logic [31:0] exp;
    } vec_t;

    vec_t vt [21];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic bus_cycle(input logic [29:0] a, input logic [31:0] d, input logic [3:0] m,
                             output logic [31:0] rd, output int e);
        bus_addr   = a;
        bus_data_w = d;
        bus_mask_w = m;
        @(posedge clock);
        #1;
        rd         = bus_data_r;
        e          = cyc;
        bus_addr   = IDLE_ADDR;
        bus_data_w = '0;
        bus_mask_w = '0;
    endtask

    task automatic wr(input logic [29:0] a, input logic [31:0] d, input logic [3:0] m);
        logic [31:0] r;
        int e;
        bus_cycle(a, d, m, r, e);
    endtask

    task automatic rd_chk(input string name, input logic [29:0] a, input logic [31:0] exp);
        logic [31:0] r;
        int e;
        bus_cycle(a, 32'h0, 4'h0, r, e);
        check(name, r, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic reset_dut();
        reset      = 1'b1;
        bus_addr   = IDLE_ADDR;
        bus_data_w = '0;
        bus_mask_w = '0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    // Expected 8N1 line: first nda bits last da clocks, the rest db, then one idle-high sample.
    task automatic check_frame(input string name, input int start, input logic [7:0] b,
                               input int da, input int nda, input int db);
        int t;
        int d;
        int bad_at;
        logic bit_v;
        logic got_v;
        logic exp_v;
        t      = start;
        bad_at = -1;
        got_v  = 1'b0;
        exp_v  = 1'b0;
        for (int k = 0; k < 10; k++) begin
            d     = (k < nda) ? da : db;
            bit_v = (k == 0) ? 1'b0 : ((k == 9) ? 1'b1 : b[k-1]);
            for (int s = 0; s < d; s++) begin
                if (hist[t[14:0]] !== bit_v && bad_at < 0) begin
                    bad_at = t - start;
                    got_v  = hist[t[14:0]];
                    exp_v  = bit_v;
                end
                t++;
            end
        end
        if (hist[t[14:0]] !== 1'b1 && bad_at < 0) begin
            bad_at = t - start;
            got_v  = hist[t[14:0]];
            exp_v  = 1'b1;
        end
        n_cmp++;
        if (bad_at >= 0) begin
            n_bad++;
            $display("FAIL %s: uart_tx at clock %0d of frame got %b expected %b", name, bad_at, got_v, exp_v);
        end
    endtask

    initial begin
        logic [31:0] r;
        int e;
        int e2;
        int base_c;
        int bad;
        int dv;
        int eff;
        int n;
        logic [7:0] q [$];

        reset_dut();

        check("reset_bus_data_r", bus_data_r, 32'h0);
        check("reset_uart_tx", 32'(uart_tx), 32'h1);
        check("reset_irq_empty", 32'(irq_empty), 32'h1);

        // Register access table; every row also checks the read data of its own cycle.
        vt[0]  = '{A_STAT,  32'h0,         4'h0, 32'h0000_0002};
        vt[1]  = '{A_DATA,  32'h0,         4'h0, 32'h0};
        vt[2]  = '{A_DIV,   32'h0,         4'h0, 32'h0000_0004};
        vt[3]  = '{A_RSV,   32'h0,         4'h0, 32'h0};
        vt[4]  = '{A_ABOVE, 32'h0,         4'h0, 32'h0};
        vt[5]  = '{A_BELOW, 32'h0,         4'h0, 32'h0};
        vt[6]  = '{A_DIV,   32'h0000_1234, 4'h3, 32'h0000_0004};
        vt[7]  = '{A_DIV,   32'h0,         4'h0, 32'h0000_1234};
        vt[8]  = '{A_DIV,   32'hFFFF_FFAB, 4'h1, 32'h0000_1234};
        vt[9]  = '{A_DIV,   32'h0,         4'h0, 32'h0000_12AB};
        vt[10] = '{A_DIV,   32'hAAAA_56CC, 4'h2, 32'h0000_12AB};
        vt[11] = '{A_DIV,   32'h0,         4'h0, 32'h0000_56AB};
        vt[12] = '{A_DIV,   32'h9999_9999, 4'hC, 32'h0000_56AB};
        vt[13] = '{A_DIV,   32'h0,         4'h0, 32'h0000_56AB};
        vt[14] = '{A_DATA,  32'h0000_0077, 4'h2, 32'h0};
        vt[15] = '{A_STAT,  32'h0,         4'h0, 32'h0000_0002};
        vt[16] = '{A_RSV,   32'hFFFF_FFFF, 4'hF, 32'h0};
        vt[17] = '{A_RSV,   32'h0,         4'h0, 32'h0};
        vt[18] = '{A_BELOW + 30'd2, 32'h0000_0007, 4'hF, 32'h0};
        vt[19] = '{A_DIV,   32'h0000_0004, 4'h3, 32'h0000_56AB};
        vt[20] = '{A_DIV,   32'h0,         4'h0, 32'h0000_0004};

        for (int i = 0; i < 21; i++) begin
            bus_cycle(vt[i].addr, vt[i].wdata, vt[i].mask, r, e);
            n_cmp++;
            if (r !== vt[i].exp) begin
                n_bad++;
                $display("FAIL vec[%0d]: bus_data_r got %h expected %h", i, r, vt[i].exp);
            end
        end

        // A5 at divisor 4: line falls one clock after the write edge, 40-clock frame.
        bus_cycle(A_DATA, 32'h0000_00A5, 4'h1, r, e);
        idle(3);
        check("irq_empty_busy", 32'(irq_empty), 32'h0);
        idle(44);
        check("a5_line_before_start", 32'(hist[e[14:0]]), 32'h1);
        check_frame("a5_frame", e + 1, 8'hA5, 4, 10, 4);
        check("irq_empty_after_a5", 32'(irq_empty), 32'h1);

        // Overflow with 4-entry FIFO and a slow divisor.
        wr(A_DIV, 32'd100, 4'h3);
        for (int i = 0; i < 6; i++) begin
            wr(A_DATA, 32'h10 + 32'(i), 4'h1);
        end
        rd_chk("status_overflow", A_STAT, 32'h0000_0405);
        bus_cycle(A_STAT, 32'h0000_0004, 4'h1, r, e);
        check("status_during_clear", r, 32'h0000_0405);
        rd_chk("status_cleared", A_STAT, 32'h0000_0401);

        // Divisor 0 behaves as 1 clock per bit.
        reset_dut();
        wr(A_DIV, 32'h0, 4'h3);
        bus_cycle(A_DATA, 32'h0000_00FF, 4'h1, r, e);
        idle(15);
        check_frame("div0_frame", e + 1, 8'hFF, 1, 10, 1);

        // Divisor change during data bit 1 of the first frame.
        wr(A_DIV, 32'd2, 4'h3);
        bus_cycle(A_DATA, 32'h0000_003C, 4'h1, r, e);
        bus_cycle(A_DATA, 32'h0000_00C9, 4'h1, r, e2);
        idle(4);
        wr(A_DIV, 32'd6, 4'h3);
        idle(120);
        check_frame("divchg_frame1", e + 1, 8'h3C, 2, 3, 6);
        check_frame("divchg_frame2", e + 1 + 48 + 1, 8'hC9, 6, 10, 6);

        // Asynchronous reset during data bit 3.
        wr(A_DIV, 32'd10, 4'h3);
        bus_cycle(A_DATA, 32'h0000_00F0, 4'h1, r, e);
        wr(A_DATA, 32'h0000_0055, 4'h1);
        idle(43);
        check("pre_reset_bit3", 32'(uart_tx), 32'h0);
        #3;
        reset = 1'b1;
        #1;
        check("async_reset_uart_tx", 32'(uart_tx), 32'h1);
        check("async_reset_irq_empty", 32'(irq_empty), 32'h1);
        check("async_reset_bus_data_r", bus_data_r, 32'h0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        rd_chk("status_after_reset", A_STAT, 32'h0000_0002);
        rd_chk("div_after_reset", A_DIV, 32'h0000_0004);
        base_c = cyc;
        idle(30);
        bad = 0;
        for (int t = base_c; t < base_c + 30; t++) begin
            if (hist[t[14:0]] !== 1'b1) bad++;
        end
        check("line_idle_after_reset", 32'(bad), 32'h0);

        // Randomized bursts: back-to-back frames separated by exactly one idle clock.
        for (int it = 0; it < 6; it++) begin
            dv  = int'($urandom_range(0, 4));
            eff = (dv == 0) ? 1 : dv;
            n   = int'($urandom_range(1, 5));
            q.delete();
            for (int i = 0; i < n; i++) q.push_back(8'($urandom));
            wr(A_DIV, 32'(dv), 4'h3);
            e = 0;
            for (int i = 0; i < n; i++) begin
                bus_cycle(A_DATA, 32'(q[i]), 4'h1, r, e2);
                if (i == 0) e = e2;
            end
            idle(n * (10 * eff + 1) + 4);
            for (int f = 0; f < n; f++) begin
                check_frame($sformatf("rand%0d_frame%0d", it, f), e + 1 + f * (10 * eff + 1),
                            q[f], eff, 10, eff);
            end
            rd_chk($sformatf("rand%0d_status", it), A_STAT, 32'h0000_0002);
            check($sformatf("rand%0d_irq", it), 32'(irq_empty), 32'h1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
